// File: rtl/ahb_switch_slave_port_if.sv
// AHB-Lite bus between one switch slave port and its downstream slave.
// The switch drives the address phase through the master modport.
interface ahb_switch_slave_port_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  slv_HSEL;
  logic [HADDR_SIZE-1:0] slv_HADDR;
  logic [HDATA_SIZE-1:0] slv_HWDATA;
  logic                  slv_HWRITE;
  logic [2:0]            slv_HSIZE;
  logic [2:0]            slv_HBURST;
  logic [3:0]            slv_HPROT;
  logic [1:0]            slv_HTRANS;
  logic                  slv_HMASTLOCK;
  logic                  slv_HREADY;
  logic [HDATA_SIZE-1:0] slv_HRDATA;
  logic                  slv_HREADYOUT;
  logic                  slv_HRESP;

  modport master (
    output slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
           slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADY,
    input  slv_HRDATA, slv_HREADYOUT, slv_HRESP
  );

  modport slave (
    input  slv_HSEL, slv_HADDR, slv_HWDATA, slv_HWRITE, slv_HSIZE, slv_HBURST,
           slv_HPROT, slv_HTRANS, slv_HMASTLOCK, slv_HREADY,
    output slv_HRDATA, slv_HREADYOUT, slv_HRESP
  );
endinterface

// File: rtl/ahb_switch_slave_port.sv
// Slave-port stage of an AHB3-Lite multi-layer switch: priority/round-robin
// arbitration among master ports, address-phase mux and data-phase response routing.
module ahb_switch_slave_port #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MASTERS    = 3
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [2:0]            mstpriority     [MASTERS],
  input  logic [MASTERS-1:0]    mstHSEL,
  input  logic [HADDR_SIZE-1:0] mstHADDR        [MASTERS],
  input  logic [HDATA_SIZE-1:0] mstHWDATA       [MASTERS],
  input  logic [MASTERS-1:0]    mstHWRITE,
  input  logic [2:0]            mstHSIZE        [MASTERS],
  input  logic [2:0]            mstHBURST       [MASTERS],
  input  logic [3:0]            mstHPROT        [MASTERS],
  input  logic [1:0]            mstHTRANS       [MASTERS],
  input  logic [MASTERS-1:0]    mstHMASTLOCK,
  input  logic [1:0]            mstHTRANS4sw    [MASTERS],
  input  logic [MASTERS-1:0]    mstHMASTLOCK4sw,
  input  logic [MASTERS-1:0]    can_switch,
  output logic [MASTERS-1:0]    master_granted,
  output logic [HDATA_SIZE-1:0] mstHRDATA,
  output logic [MASTERS-1:0]    mstHREADYOUT,
  output logic [MASTERS-1:0]    mstHRESP,
  ahb_switch_slave_port_if.master slv_bus
);

  localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] dp_idx;
  logic             dp_vld;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [2:0]       best_pri;
  logic             any_req;
  logic             hsel;
  logic [1:0]       htrans;
  logic             hready;
  logic             unused_trans4sw;

  function automatic logic [MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MASTERS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Priority arbitration; scanning from rr_ptr+1 with a strict compare gives ties to the RR successor
  always_comb begin
    winner   = '0;
    cand     = '0;
    best_pri = 3'd0;
    any_req  = 1'b0;
    for (int k = 1; k <= MASTERS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % MASTERS);
      if (mstHSEL[cand] && (!any_req || (mstpriority[cand] > best_pri))) begin
        any_req  = 1'b1;
        winner   = cand;
        best_pri = mstpriority[cand];
      end else begin
        any_req  = any_req;
      end
    end
  end

  // Raw switch-control transfer type is decided upstream and folded into can_switch
  always_comb begin
    unused_trans4sw = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      unused_trans4sw = unused_trans4sw ^ (^mstHTRANS4sw[i]);
    end
  end

  // Address-phase select, transfer type and bus ready
  always_comb begin
    hsel   = gnt_vld & mstHSEL[gnt_idx];
    htrans = hsel ? mstHTRANS[gnt_idx] : HTRANS_IDLE;
    hready = dp_vld ? slv_bus.slv_HREADYOUT : 1'b1;
  end

  // Grant ownership, round-robin pointer and data-phase owner tracking
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      gnt_idx        <= '0;
      gnt_vld        <= 1'b0;
      rr_ptr         <= IDX_W'(MASTERS - 1);
      dp_idx         <= '0;
      dp_vld         <= 1'b0;
      master_granted <= '0;
    end else if (hready) begin
      if (!gnt_vld) begin
        if (any_req) begin
          gnt_idx        <= winner;
          gnt_vld        <= 1'b1;
          rr_ptr         <= winner;
          master_granted <= onehot(winner);
        end else begin
          gnt_vld        <= 1'b0;
        end
      end else if (can_switch[gnt_idx] && !mstHMASTLOCK4sw[gnt_idx]) begin
        if (any_req) begin
          gnt_idx        <= winner;
          rr_ptr         <= winner;
          master_granted <= onehot(winner);
        end else begin
          gnt_vld        <= 1'b0;
          master_granted <= '0;
        end
      end else begin
        gnt_vld        <= gnt_vld;
      end
      dp_idx <= gnt_idx;
      dp_vld <= hsel && (htrans != HTRANS_IDLE);
    end else begin
      dp_vld <= dp_vld;
    end
  end

  assign slv_bus.slv_HSEL      = hsel;
  assign slv_bus.slv_HTRANS    = htrans;
  assign slv_bus.slv_HREADY    = hready;
  assign slv_bus.slv_HADDR     = mstHADDR[gnt_idx];
  assign slv_bus.slv_HWRITE    = mstHWRITE[gnt_idx];
  assign slv_bus.slv_HSIZE     = mstHSIZE[gnt_idx];
  assign slv_bus.slv_HBURST    = mstHBURST[gnt_idx];
  assign slv_bus.slv_HPROT     = mstHPROT[gnt_idx];
  assign slv_bus.slv_HMASTLOCK = mstHMASTLOCK[gnt_idx];
  assign slv_bus.slv_HWDATA    = mstHWDATA[dp_idx];
  assign mstHRDATA             = slv_bus.slv_HRDATA;

  // Only the data-phase owner sees the slave's ready and response
  always_comb begin
    for (int m = 0; m < MASTERS; m++) begin
      if (dp_vld && (dp_idx == IDX_W'(m))) begin
        mstHREADYOUT[m] = slv_bus.slv_HREADYOUT;
        mstHRESP[m]     = slv_bus.slv_HRESP;
      end else begin
        mstHREADYOUT[m] = 1'b1;
        mstHRESP[m]     = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_switch_slave_port.sv
// Directed self-checking bench for ahb_switch_slave_port (3 masters, 32-bit bus).
module tb_ahb_switch_slave_port;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [2:0]  mstpriority     [3];
  logic [2:0]  mstHSEL;
  logic [31:0] mstHADDR        [3];
  logic [31:0] mstHWDATA       [3];
  logic [2:0]  mstHWRITE;
  logic [2:0]  mstHSIZE        [3];
  logic [2:0]  mstHBURST       [3];
  logic [3:0]  mstHPROT        [3];
  logic [1:0]  mstHTRANS       [3];
  logic [2:0]  mstHMASTLOCK;
  logic [1:0]  mstHTRANS4sw    [3];
  logic [2:0]  mstHMASTLOCK4sw;
  logic [2:0]  can_switch;
  logic [2:0]  master_granted;
  logic [31:0] mstHRDATA;
  logic [2:0]  mstHREADYOUT;
  logic [2:0]  mstHRESP;

  int n_cmp  = 0;
  int n_fail = 0;

  ahb_switch_slave_port_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) slv_bus ();

  ahb_switch_slave_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .mstpriority(mstpriority), .mstHSEL(mstHSEL),
    .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE),
    .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
    .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHTRANS4sw(mstHTRANS4sw),
    .mstHMASTLOCK4sw(mstHMASTLOCK4sw), .can_switch(can_switch),
    .master_granted(master_granted), .mstHRDATA(mstHRDATA),
    .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP), .slv_bus(slv_bus.master)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    mstHSEL = 3'b000; mstHWRITE = 3'b000; mstHMASTLOCK = 3'b000;
    mstHMASTLOCK4sw = 3'b000; can_switch = 3'b111;
    for (int i = 0; i < 3; i++) begin
      mstpriority[i] = 3'd0; mstHADDR[i] = 32'h0; mstHWDATA[i] = 32'h0;
      mstHSIZE[i] = 3'b010; mstHBURST[i] = 3'b000; mstHPROT[i] = 4'b0011;
      mstHTRANS[i] = 2'b00; mstHTRANS4sw[i] = 2'b00;
    end
    slv_bus.slv_HRDATA = 32'h0; slv_bus.slv_HREADYOUT = 1'b1; slv_bus.slv_HRESP = 1'b0;
    step();
    step();
    HRESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (master_granted !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", master_granted); end
    n_cmp++; if (slv_bus.slv_HSEL !== 1'b0) begin n_fail++; $display("FAIL reset_hsel: got %b want 0", slv_bus.slv_HSEL); end
    n_cmp++; if (slv_bus.slv_HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans: got %b want 00", slv_bus.slv_HTRANS); end
    n_cmp++; if (slv_bus.slv_HREADY !== 1'b1) begin n_fail++; $display("FAIL reset_hready: got %b want 1", slv_bus.slv_HREADY); end
    n_cmp++; if (mstHREADYOUT !== 3'b111) begin n_fail++; $display("FAIL reset_readyout: got %b want 111", mstHREADYOUT); end
    n_cmp++; if (mstHRESP !== 3'b000) begin n_fail++; $display("FAIL reset_resp: got %b want 000", mstHRESP); end
  endtask

  task automatic test_single();
    do_reset();
    mstHSEL = 3'b010; mstHTRANS[1] = 2'b10; mstHADDR[1] = 32'h100;
    mstHWRITE = 3'b010; mstHWDATA[1] = 32'hDEAD0001; mstHSIZE[1] = 3'b001;
    step();
    n_cmp++; if (master_granted !== 3'b010) begin n_fail++; $display("FAIL single_gnt: got %b want 010", master_granted); end
    n_cmp++; if (slv_bus.slv_HADDR !== 32'h100) begin n_fail++; $display("FAIL single_haddr: got %h want 100", slv_bus.slv_HADDR); end
    n_cmp++; if (slv_bus.slv_HSEL !== 1'b1 || slv_bus.slv_HTRANS !== 2'b10) begin n_fail++; $display("FAIL single_sel_trans: got %b/%b want 1/10", slv_bus.slv_HSEL, slv_bus.slv_HTRANS); end
    n_cmp++; if (slv_bus.slv_HWRITE !== 1'b1 || slv_bus.slv_HSIZE !== 3'b001) begin n_fail++; $display("FAIL single_ctrl: got %b/%b want 1/001", slv_bus.slv_HWRITE, slv_bus.slv_HSIZE); end
    step();
    mstHSEL = 3'b000; mstHTRANS[1] = 2'b00; slv_bus.slv_HREADYOUT = 1'b0;
    #1;
    n_cmp++; if (slv_bus.slv_HWDATA !== 32'hDEAD0001) begin n_fail++; $display("FAIL single_hwdata: got %h want dead0001", slv_bus.slv_HWDATA); end
    n_cmp++; if (mstHREADYOUT !== 3'b101) begin n_fail++; $display("FAIL single_readyout_low: got %b want 101", mstHREADYOUT); end
    n_cmp++; if (slv_bus.slv_HREADY !== 1'b0) begin n_fail++; $display("FAIL single_hready_low: got %b want 0", slv_bus.slv_HREADY); end
    slv_bus.slv_HREADYOUT = 1'b1;
    #1;
    n_cmp++; if (mstHREADYOUT !== 3'b111) begin n_fail++; $display("FAIL single_readyout_high: got %b want 111", mstHREADYOUT); end
    step();
    n_cmp++; if (master_granted !== 3'b000) begin n_fail++; $display("FAIL single_release: got %b want 000", master_granted); end
  endtask

  task automatic test_priority();
    do_reset();
    mstpriority[0] = 3'd1; mstpriority[2] = 3'd5; mstHSEL = 3'b101;
    mstHTRANS[0] = 2'b10; mstHTRANS[2] = 2'b10;
    mstHADDR[0] = 32'h200; mstHADDR[2] = 32'h300;
    step();
    n_cmp++; if (master_granted !== 3'b100) begin n_fail++; $display("FAIL prio_high: got %b want 100", master_granted); end
    n_cmp++; if (slv_bus.slv_HADDR !== 32'h300) begin n_fail++; $display("FAIL prio_haddr: got %h want 300", slv_bus.slv_HADDR); end
    step();
    mstHSEL = 3'b001; mstHTRANS[2] = 2'b00;
    step();
    n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL prio_fallback: got %b want 001", master_granted); end
    n_cmp++; if (slv_bus.slv_HADDR !== 32'h200 || slv_bus.slv_HSEL !== 1'b1) begin n_fail++; $display("FAIL prio_fallback_addr: got %h/%b want 200/1", slv_bus.slv_HADDR, slv_bus.slv_HSEL); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt [4];
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100; exp_gnt[3] = 3'b001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mstpriority[i] = 3'd2; mstHTRANS[i] = 2'b10; mstHADDR[i] = 32'h1000 + 32'(i * 16);
    end
    mstHSEL = 3'b111;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (master_granted !== exp_gnt[c]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, master_granted, exp_gnt[c]); end
      n_cmp++; if (slv_bus.slv_HADDR !== 32'h1000 + 32'((c % 3) * 16)) begin n_fail++; $display("FAIL rr_haddr[%0d]: got %h want %h", c, slv_bus.slv_HADDR, 32'h1000 + 32'((c % 3) * 16)); end
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    mstpriority[0] = 3'd1; mstpriority[1] = 3'd4;
    mstHSEL = 3'b001; mstHTRANS[0] = 2'b10; mstHBURST[0] = 3'b011;
    step();
    n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL burst_start: got %b want 001", master_granted); end
    can_switch = 3'b110; mstHTRANS[0] = 2'b11; mstHSEL = 3'b011; mstHTRANS[1] = 2'b10;
    for (int b = 0; b < 3; b++) begin
      step();
      n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL burst_hold[%0d]: got %b want 001", b, master_granted); end
    end
    n_cmp++; if (slv_bus.slv_HBURST !== 3'b011) begin n_fail++; $display("FAIL burst_hburst: got %b want 011", slv_bus.slv_HBURST); end
    can_switch = 3'b111;
    step();
    n_cmp++; if (master_granted !== 3'b010) begin n_fail++; $display("FAIL burst_switch: got %b want 010", master_granted); end

    do_reset();
    mstpriority[0] = 3'd1; mstpriority[1] = 3'd4;
    mstHSEL = 3'b001; mstHTRANS[0] = 2'b10; mstHMASTLOCK = 3'b001; mstHMASTLOCK4sw = 3'b001;
    step();
    mstHSEL = 3'b011; mstHTRANS[1] = 2'b10;
    for (int b = 0; b < 3; b++) begin
      step();
      n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL lock_hold[%0d]: got %b want 001", b, master_granted); end
    end
    n_cmp++; if (slv_bus.slv_HMASTLOCK !== 1'b1) begin n_fail++; $display("FAIL lock_hmastlock: got %b want 1", slv_bus.slv_HMASTLOCK); end
    mstHMASTLOCK = 3'b000; mstHMASTLOCK4sw = 3'b000;
    step();
    n_cmp++; if (master_granted !== 3'b010) begin n_fail++; $display("FAIL lock_release: got %b want 010", master_granted); end
  endtask

  task automatic test_wait_states();
    do_reset();
    mstHSEL = 3'b001; mstHTRANS[0] = 2'b10; mstHADDR[0] = 32'h400; mstHADDR[1] = 32'h500;
    step();
    n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL wait_gnt0: got %b want 001", master_granted); end
    can_switch = 3'b110; mstpriority[1] = 3'd3; mstHSEL = 3'b011; mstHTRANS[1] = 2'b10;
    step();
    slv_bus.slv_HREADYOUT = 1'b0; can_switch = 3'b111;
    for (int w = 0; w < 2; w++) begin
      #1;
      n_cmp++; if (slv_bus.slv_HREADY !== 1'b0) begin n_fail++; $display("FAIL wait_hready[%0d]: got %b want 0", w, slv_bus.slv_HREADY); end
      n_cmp++; if (mstHREADYOUT !== 3'b110) begin n_fail++; $display("FAIL wait_readyout[%0d]: got %b want 110", w, mstHREADYOUT); end
      n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL wait_gnt_hold[%0d]: got %b want 001", w, master_granted); end
      step();
    end
    n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL wait_gnt_end: got %b want 001", master_granted); end
    slv_bus.slv_HREADYOUT = 1'b1;
    step();
    n_cmp++; if (master_granted !== 3'b010 || slv_bus.slv_HADDR !== 32'h500) begin n_fail++; $display("FAIL wait_switch: got %b/%h want 010/500", master_granted, slv_bus.slv_HADDR); end
  endtask

  task automatic test_error_resp();
    do_reset();
    mstHSEL = 3'b100; mstHTRANS[2] = 2'b10;
    step();
    step();
    slv_bus.slv_HRESP = 1'b1; slv_bus.slv_HREADYOUT = 1'b0; slv_bus.slv_HRDATA = 32'hCAFEF00D;
    #1;
    n_cmp++; if (mstHRESP !== 3'b100 || mstHREADYOUT !== 3'b011) begin n_fail++; $display("FAIL err_first: got %b/%b want 100/011", mstHRESP, mstHREADYOUT); end
    n_cmp++; if (mstHRDATA !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_hrdata: got %h want cafef00d", mstHRDATA); end
    step();
    slv_bus.slv_HREADYOUT = 1'b1;
    #1;
    n_cmp++; if (mstHRESP !== 3'b100 || mstHREADYOUT !== 3'b111) begin n_fail++; $display("FAIL err_second: got %b/%b want 100/111", mstHRESP, mstHREADYOUT); end
    n_cmp++; if (master_granted !== 3'b100) begin n_fail++; $display("FAIL err_gnt: got %b want 100", master_granted); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mstHSEL = 3'b001; mstHTRANS[0] = 2'b10;
    step();
    step();
    slv_bus.slv_HREADYOUT = 1'b0;
    HRESET = 1'b1;
    step();
    n_cmp++; if (master_granted !== 3'b000) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 000", master_granted); end
    n_cmp++; if (slv_bus.slv_HTRANS !== 2'b00 || slv_bus.slv_HSEL !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus: got %b/%b want 00/0", slv_bus.slv_HTRANS, slv_bus.slv_HSEL); end
    n_cmp++; if (mstHREADYOUT !== 3'b111 || slv_bus.slv_HREADY !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b/%b want 111/1", mstHREADYOUT, slv_bus.slv_HREADY); end
    HRESET = 1'b0; slv_bus.slv_HREADYOUT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mstpriority[i] = 3'd2; mstHTRANS[i] = 2'b10;
    end
    mstHSEL = 3'b111;
    step();
    n_cmp++; if (master_granted !== 3'b001) begin n_fail++; $display("FAIL rstmid_first: got %b want 001", master_granted); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_burst_lock();
    test_wait_states();
    test_error_resp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
